cacheline_arbiter: RTL and testbench
====================================

# cacheline_arbiter

Arbitrates the instruction-cache and data-cache miss/writeback traffic onto the single cacheline-wide physical memory port. Sits between the two L1 caches, which the IF and MEM stages drive, and the memory side. It grants one requester at a time with round-robin fairness. It registers the memory command so it stays stable for the whole transaction, and routes the completion back only to the granted cache.

## Interface
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, byte address width
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  ADDR_W  I-cache line address (low 5 bits zero)
- i_rdata  out  LINE_W  line data to I-cache, valid when i_resp=1
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback data
- d_rdata  out  LINE_W  line data to D-cache, valid when d_resp=1
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  registered memory read command
- mem_write  out  1  registered memory write command
- mem_address  out  ADDR_W  registered memory address
- mem_wdata  out  LINE_W  registered memory write data
- mem_rdata  in  LINE_W  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion pulse

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D. Register last_grant (I/D).
- IDLE:
  - No request: stay in IDLE.
  - Only i_read: go to SERVE_I.
  - Only d_read or d_write: go to SERVE_D.
  - Both requesting: grant the side that is not last_grant.
- On entry to SERVE_x, latch the requester's address, command and wdata into the mem_* registers. Update last_grant to x.
- SERVE_x: hold mem_* constant and ignore all requester inputs. On mem_resp=1, clear mem_read and mem_write, pulse x_resp for that same cycle, and go to IDLE.
- d_read and d_write both 1 (illegal): treated as a write. mem_write=1, mem_read=0.
- mem_rdata is combinationally forwarded to both i_rdata and d_rdata. Only the resp of the granted side is raised: i_resp = (state==SERVE_I) & mem_resp; d_resp = (state==SERVE_D) & mem_resp.
- mem_resp in IDLE: ignored. No resp pulses, no state change.
- Requester drops its request mid-transaction: the transaction still runs to mem_resp, because memory cannot abort. The resp pulse is still issued.
- Reset asserted at any time, including mid-transaction: immediately go to IDLE with last_grant=D, so the first tie goes to I. All outputs 0: mem_read, mem_write, mem_address, mem_wdata, i_resp, d_resp. The rdata outputs follow mem_rdata.

## Timing
- Grant latency: a request sampled in IDLE at edge k drives mem_read or mem_write high from cycle k+1.
- Completion: if mem_resp is high in cycle N, x_resp is high in cycle N with zero added latency. mem_read and mem_write are low from N+1.
- Minimum one IDLE cycle between transactions. After a resp in cycle N, the next command is asserted at the earliest in cycle N+2.
- Requesters must deassert at the edge where they see x_resp. A request still high in the IDLE cycle is treated as a new request.
- Back-to-back alternation under continuous contention: I, D, I, D...
- No starvation: a waiting requester is served next after the current transaction.
- mem_address and mem_wdata never change while mem_read or mem_write is 1.

## Test plan
- Reset then idle: hold rst=0 for 3 cycles, then release with no requests -> all mem_* and resp outputs stay 0 for 10 cycles.
- Single I read: i_read=1, i_address=0x0000_1000, memory responds after 4 cycles with rdata=256'hA5…A5.
  - mem_read=1 and mem_address=0x1000 from the cycle after the request.
  - i_resp=1 for exactly 1 cycle with i_rdata=A5…A5; d_resp stays 0.
- Simultaneous requests out of reset: i_read (0x100) and d_write (0x200, wdata=0xDEAD…) in the same cycle.
  - I is served first.
  - After i_resp, one IDLE cycle, then mem_write=1, mem_address=0x200, mem_wdata=0xDEAD…, then d_resp.
- Continuous contention: i_read and d_read held high, re-asserted after every resp, for 6 transactions -> grant order I, D, I, D, I, D.
- Stability: d_address changes to 0x300 while SERVE_D for 0x200 is pending -> mem_address stays 0x200 until mem_resp.
- Reset mid-transaction: rst=0 during SERVE_I before mem_resp -> mem_read=0 asynchronously and the FSM is in IDLE. A later mem_resp produces no i_resp.

Source files
------------

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin arbiter between the I-cache and D-cache
// line traffic and a single cacheline-wide memory port. The memory command
// is registered at grant and held until mem_resp; completion is routed back
// only to the granted cache.
module cacheline_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last_d, last_d_nxt;   // 1 = D was granted last
  logic              rd_nxt, wr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LINE_W-1:0] wdata_nxt;
  logic              req_i, req_d, pick_d;

  assign req_i  = i_read;
  assign req_d  = d_read | d_write;
  // On a tie the side that was not granted last wins.
  assign pick_d = req_d & (~req_i | ~last_d);

  // Next-state, grant selection and next memory command.
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    rd_nxt     = mem_read;
    wr_nxt     = mem_write;
    addr_nxt   = mem_address;
    wdata_nxt  = mem_wdata;
    unique case (state)
      IDLE: begin
        if (req_i | req_d) begin
          if (pick_d) begin
            state_nxt  = SERVE_D;
            last_d_nxt = 1'b1;
            // read+write together is treated as a writeback
            wr_nxt     = d_write;
            rd_nxt     = ~d_write;
            addr_nxt   = d_address;
            wdata_nxt  = d_wdata;
          end else begin
            state_nxt  = SERVE_I;
            last_d_nxt = 1'b0;
            rd_nxt     = 1'b1;
            wr_nxt     = 1'b0;
            addr_nxt   = i_address;
            wdata_nxt  = '0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_nxt = IDLE;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant history and registered memory command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_d      <= 1'b1;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_nxt;
      last_d      <= last_d_nxt;
      mem_read    <= rd_nxt;
      mem_write   <= wr_nxt;
      mem_address <= addr_nxt;
      mem_wdata   <= wdata_nxt;
    end
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_resp  = (state == SERVE_I) & mem_resp;
  assign d_resp  = (state == SERVE_D) & mem_resp;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: transaction-level model plus
// directed scenarios with hand-computed expectations.
module tb_cacheline_arbiter;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One outstanding transaction at most; a new one may only be accepted
  // at an edge where nothing is outstanding.
  logic              m_busy;
  logic              m_owner_d;
  logic              m_last_d;
  logic              m_read, m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  int                grants[$];   // 0 = I, 1 = D, in grant order

  logic want_i, want_d, choose_d;
  assign want_i   = i_read;
  assign want_d   = d_read || d_write;
  assign choose_d = (want_i && want_d) ? (m_last_d == 1'b0) : want_d;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy    <= 1'b0;
      m_owner_d <= 1'b0;
      m_last_d  <= 1'b1;
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else if (!m_busy) begin
      if (want_i || want_d) begin
        m_busy    <= 1'b1;
        m_owner_d <= choose_d;
        m_last_d  <= choose_d;
        grants.push_back(choose_d ? 1 : 0);
        if (choose_d) begin
          m_write <= d_write;
          m_read  <= !d_write;
          m_addr  <= d_address;
          m_wdata <= d_wdata;
        end else begin
          m_write <= 1'b0;
          m_read  <= 1'b1;
          m_addr  <= i_address;
        end
      end
    end else if (mem_resp) begin
      m_busy  <= 1'b0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk1("cyc_mem_read", mem_read, m_read);
    chk1("cyc_mem_write", mem_write, m_write);
    chk32("cyc_mem_address", mem_address, m_addr);
    if (m_write) chk256("cyc_mem_wdata", mem_wdata, m_wdata);
    chk1("cyc_i_resp", i_resp, m_busy && !m_owner_d && mem_resp);
    chk1("cyc_d_resp", d_resp, m_busy && m_owner_d && mem_resp);
    chk256("cyc_i_rdata", i_rdata, mem_rdata);
    chk256("cyc_d_rdata", d_rdata, mem_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [LINE_W-1:0] pat_a5, pat_dead, pat_w6;
  int exp_order[6];

  initial begin
    pat_a5   = {32{8'hA5}};
    pat_dead = {16{16'hDEAD}};
    pat_w6   = {8{32'h6060_1234}};
    exp_order = '{0, 1, 0, 1, 0, 1};

    rst = 1'b0; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;

    // reset then idle
    repeat (3) tick();
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk32("rst_mem_address", mem_address, 32'h0);
    chk256("rst_mem_wdata", mem_wdata, '0);
    rst = 1'b1;
    repeat (10) tick();
    chk1("idle_mem_read", mem_read, 1'b0);
    chk1("idle_i_resp", i_resp, 1'b0);

    // single I read, memory answers in the 4th serve cycle
    i_read = 1'b1; i_address = 32'h0000_1000;
    tick();
    chk1("i1_mem_read", mem_read, 1'b1);
    chk1("i1_mem_write", mem_write, 1'b0);
    chk32("i1_mem_address", mem_address, 32'h1000);
    repeat (3) tick();
    mem_resp = 1'b1; mem_rdata = pat_a5;
    #1;
    chk1("i1_i_resp", i_resp, 1'b1);
    chk256("i1_i_rdata", i_rdata, pat_a5);
    chk1("i1_d_resp", d_resp, 1'b0);
    tick();
    mem_resp = 1'b0; mem_rdata = '0; i_read = 1'b0;
    #1;
    chk1("i1_resp_gone", i_resp, 1'b0);
    chk1("i1_read_low", mem_read, 1'b0);
    tick();

    // simultaneous requests out of reset: I first, then D writeback
    rst = 1'b0;
    tick();
    rst = 1'b1;
    i_read = 1'b1; i_address = 32'h100;
    d_write = 1'b1; d_address = 32'h200; d_wdata = pat_dead;
    tick();
    chk1("tie_mem_read", mem_read, 1'b1);
    chk32("tie_mem_address", mem_address, 32'h100);
    tick();
    mem_resp = 1'b1; mem_rdata = pat_a5;
    #1;
    chk1("tie_i_resp", i_resp, 1'b1);
    chk1("tie_d_resp_lo", d_resp, 1'b0);
    tick();
    mem_resp = 1'b0; i_read = 1'b0;
    #1;
    chk1("gap_mem_read", mem_read, 1'b0);
    chk1("gap_mem_write", mem_write, 1'b0);
    tick();
    chk1("dw_mem_write", mem_write, 1'b1);
    chk1("dw_mem_read", mem_read, 1'b0);
    chk32("dw_mem_address", mem_address, 32'h200);
    chk256("dw_mem_wdata", mem_wdata, pat_dead);
    d_address = 32'h300;
    repeat (2) tick();
    chk32("stable_mem_address", mem_address, 32'h200);
    mem_resp = 1'b1;
    #1;
    chk1("dw_d_resp", d_resp, 1'b1);
    chk1("dw_i_resp", i_resp, 1'b0);
    chk32("stable_at_resp", mem_address, 32'h200);
    tick();
    mem_resp = 1'b0; d_write = 1'b0;
    #1;
    chk1("dw_write_low", mem_write, 1'b0);
    tick();

    // continuous contention: must alternate I, D, I, D, I, D
    grants.delete();
    i_read = 1'b1; i_address = 32'h400;
    d_read = 1'b1; d_address = 32'h500;
    for (int k = 0; k < 6; k++) begin
      tick();
      tick();
      mem_resp = 1'b1; mem_rdata = {8{k[31:0]}};
      tick();
      mem_resp = 1'b0;
      if (k == 5) begin
        i_read = 1'b0; d_read = 1'b0;
      end
    end
    tick();
    n_checks++;
    if (grants.size() != 6) begin
      n_fail++;
      $display("FAIL rr_count: got %0d expected 6", grants.size());
    end else begin
      for (int k = 0; k < 6; k++)
        chk32("rr_order", grants[k], exp_order[k]);
    end

    // read+write together acts as a write; mem_resp in IDLE is ignored
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h600; d_wdata = pat_w6;
    tick();
    chk1("rw_mem_write", mem_write, 1'b1);
    chk1("rw_mem_read", mem_read, 1'b0);
    chk32("rw_mem_address", mem_address, 32'h600);
    chk256("rw_mem_wdata", mem_wdata, pat_w6);
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick();
    mem_resp = 1'b1;
    #1;
    chk1("idle_resp_i", i_resp, 1'b0);
    chk1("idle_resp_d", d_resp, 1'b0);
    tick();
    mem_resp = 1'b0;
    #1;
    chk1("idle_resp_nocmd", mem_read | mem_write, 1'b0);
    tick();

    // reset in the middle of an I transaction
    i_read = 1'b1; i_address = 32'h700;
    tick();
    chk1("mid_mem_read", mem_read, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk1("mid_rst_mem_read", mem_read, 1'b0);
    chk32("mid_rst_address", mem_address, 32'h0);
    i_read = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    mem_resp = 1'b1;
    #1;
    chk1("mid_late_i_resp", i_resp, 1'b0);
    chk1("mid_late_mem_read", mem_read, 1'b0);
    tick();
    mem_resp = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
